// File: rtl/simon_round_controller.sv
// Simon Says round sequencer: plays back a packed direction pattern, then checks the player's presses.
// Define SIMON_EARLY_PRESS_EN to make a press during playback lose the round.
module simon_round_controller #(
   parameter int unsigned NUM_STEPS      = 3,
   parameter int unsigned HOLD_CYCLES    = 4,
   parameter int unsigned TIMEOUT_CYCLES = 16
) (
   input  logic                               clock,
   input  logic                               reset,
   input  logic                               start,
   input  logic [2*NUM_STEPS-1:0]             pattern,
   input  logic                               player_valid,
   input  logic [1:0]                         player_dir,
   output logic                               display_valid,
   output logic [1:0]                         display_dir,
   output logic                               busy,
   output logic                               win,
   output logic                               lose,
   output logic [$clog2(NUM_STEPS+1)-1:0]     score
);

   localparam int unsigned PW   = 2 * NUM_STEPS;
   localparam int unsigned SW   = $clog2(NUM_STEPS + 1);
   localparam int unsigned TMAX = (HOLD_CYCLES > TIMEOUT_CYCLES) ? HOLD_CYCLES : TIMEOUT_CYCLES;
   localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   localparam logic [SW-1:0] LastStep = SW'(NUM_STEPS - 1);
   localparam logic [TW-1:0] HoldLast = TW'(HOLD_CYCLES - 1);
   localparam logic [TW-1:0] ToLast   = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StShow, StGap, StInput, StWin, StLose} state_e;

   state_e        state_q, state_d;
   logic [PW-1:0] shift_q, shift_d;
   logic [PW-1:0] saved_q, saved_d;
   logic [SW-1:0] step_q, step_d;
   logic [TW-1:0] timer_q, timer_d;
   logic [SW-1:0] score_d;

   always_comb begin
      state_d = state_q;
      shift_d = shift_q;
      saved_d = saved_q;
      step_d  = step_q;
      timer_d = timer_q;
      score_d = score;
      unique case (state_q)
         StIdle, StWin, StLose: begin
            if (start) begin
               shift_d = pattern;
               saved_d = pattern;
               step_d  = '0;
               timer_d = '0;
               score_d = '0;
               state_d = StShow;
            end
         end
         StShow: begin
            if (timer_q == HoldLast) begin
               timer_d = '0;
               if (step_q == LastStep) begin
                  // Playback done: rewind so INPUT checks from step 0 again.
                  shift_d = saved_q;
                  step_d  = '0;
                  state_d = StInput;
               end else begin
                  shift_d = shift_q << 2;
                  step_d  = step_q + 1'b1;
                  state_d = StGap;
               end
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         StGap: state_d = StShow;
         StInput: begin
            // A press on the timeout cycle wins over the timeout.
            if (player_valid) begin
               if (player_dir == shift_q[PW-1 -: 2]) begin
                  score_d = score + 1'b1;
                  timer_d = '0;
                  shift_d = shift_q << 2;
                  step_d  = step_q + 1'b1;
                  if (step_q == LastStep) state_d = StWin;
               end else begin
                  state_d = StLose;
               end
            end else if (timer_q == ToLast) begin
               state_d = StLose;
            end else begin
               timer_d = timer_q + 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
`ifdef SIMON_EARLY_PRESS_EN
      if (player_valid && (state_q == StShow || state_q == StGap)) state_d = StLose;
`endif
   end

   // Outputs are registered from next-state values so they line up with the state.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= StIdle;
         shift_q       <= '0;
         saved_q       <= '0;
         step_q        <= '0;
         timer_q       <= '0;
         display_valid <= 1'b0;
         display_dir   <= 2'b00;
         busy          <= 1'b0;
         win           <= 1'b0;
         lose          <= 1'b0;
         score         <= '0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         saved_q       <= saved_d;
         step_q        <= step_d;
         timer_q       <= timer_d;
         display_valid <= (state_d == StShow);
         display_dir   <= (state_d == StShow) ? shift_d[PW-1 -: 2] : 2'b00;
         busy          <= (state_d == StShow) || (state_d == StGap) || (state_d == StInput);
         win           <= (state_d == StWin);
         lose          <= (state_d == StLose);
         score         <= score_d;
      end
   end

endmodule

// File: doc/simon_round_controller.md
Name: simon_round_controller

Overview:
Sequences one Simon Says round. Captures a packed direction pattern and plays it back one direction at a time on a timed display strobe. It then checks player presses against the same pattern, shifting 2 bits per step, MSB pair first. Sits between the game top level (start, pattern source, LEDs/buttons) and the win/lose/score logic.

Parameters:
NUM_STEPS, 3, directions per round; pattern width is 2*NUM_STEPS.
HOLD_CYCLES, 4, clock cycles each direction is shown (board build overrides, e.g. 25000000).
TIMEOUT_CYCLES, 16, idle cycles allowed per press in INPUT before loss.

Ports:
clock  input  1  system clock, rising edge.
reset  input  1  synchronous, active-high reset.
start  input  1  begin round; sampled only in IDLE/WIN/LOSE.
pattern  input  2*NUM_STEPS  directions, step 0 in [2N-1:2N-2]; captured on accepted start.
player_valid  input  1  one-cycle press strobe.
player_dir  input  2  pressed direction, valid with player_valid.
display_valid  output  1  high while a direction is being shown.
display_dir  output  2  direction shown; 0 when display_valid=0.
busy  output  1  high in SHOW, GAP, INPUT.
win  output  1  level, high in WIN.
lose  output  1  level, high in LOSE.
score  output  $clog2(NUM_STEPS+1)  correct presses this round.

Behaviour:
- States: IDLE, SHOW, GAP, INPUT, WIN, LOSE. All outputs registered.
- Reset, including mid-round, at the next edge: state IDLE. All outputs 0. Shift reg, saved pattern, step counter, timer 0.
- IDLE/WIN/LOSE on start:
  - load pattern into shift reg and saved copy; step=0, timer=0, score=0; go to SHOW.
  - win/lose clear on the same edge.
  - start while busy is ignored.
- SHOW:
  - display_valid=1, display_dir=shift reg top pair.
  - timer counts 0..HOLD_CYCLES-1.
  - At HOLD_CYCLES-1: timer=0.
    - If step==NUM_STEPS-1: reload shift reg from saved copy, step=0, go to INPUT.
    - Else: shift left by 2 (zero fill), step++, go to GAP.
- GAP: exactly 1 cycle, display_valid=0, display_dir=0; then SHOW.
- INPUT:
  - Expected direction = shift reg top pair. Timer counts idle cycles.
  - player_valid with player_dir==expected: score++, timer=0, shift left 2, step++. If that was step NUM_STEPS-1, go to WIN.
  - player_valid with mismatch: go to LOSE; score unchanged.
  - No press while timer==TIMEOUT_CYCLES-1: go to LOSE.
  - A press on the timeout cycle takes priority over the timeout.
- WIN/LOSE hold until start or reset. score holds its final value.
- player_valid is ignored in IDLE/WIN/LOSE, and in SHOW/GAP unless the macro below is defined.
- Round timing, start sampled at cycle 0:
  - SHOW on cycles 1..HOLD, GAPs between steps.
  - INPUT entered at cycle NUM_STEPS*HOLD_CYCLES + (NUM_STEPS-1) + 1.
- Counters are sized $clog2 of their max + 1 and never wrap in legal operation.

Optional Feature:
SIMON_EARLY_PRESS_EN
- Defined: player_valid in SHOW or GAP forces LOSE at the next edge; display_valid drops to 0.
- Undefined: such presses are ignored and playback continues unaffected.

Test Plan:
1. Defaults, pattern=6'b10_01_11, start at cycle 0 -> display_dir=2 cycles 1-4, 0 at cycle 5, 1 cycles 6-9, 0 at cycle 10, 3 cycles 11-14; busy=1; INPUT from cycle 15.
2. Continue 1: press 2,1,3 on spaced cycles -> score 1,2,3; win=1 and busy=0 the edge after the third press; lose=0.
3. Continue 1: press 2 then 0 -> score=1, lose=1 next edge; a new start clears lose and replays the pattern.
4. Continue 1: no press for 16 cycles -> lose=1 on cycle 31; score=0.
5. Reset asserted at cycle 7 mid-SHOW -> next edge all outputs 0 and state IDLE. A start pulsed at cycle 3 of a live round has no effect on timing.
6. Press dir=2 at cycle 2:
   - with SIMON_EARLY_PRESS_EN -> lose=1 at cycle 3, display_valid=0;
   - without -> sequence identical to scenario 1.
